// File: rtl/ser_pkg.sv
// Shared types and defaults for the FIFO word serializer.
// The optional SER_PARITY_EN build macro is consumed by ser_lane_mux and fifo_word_serializer.
package ser_pkg;

   localparam int unsigned WORD_W_DEF = 32;
   localparam int unsigned BYTE_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      CAPTURE,
      SEND
   } ser_state_t;

   // Index width for a lane counter; a single-lane word still needs one bit.
   function automatic int unsigned idx_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/ser_lane_mux.sv
// Combinational lane selector: picks lane[idx_i] of the captured word (lane 0 = LSBs).
// With SER_PARITY_EN defined it also produces even parity of the selected lane.
module ser_lane_mux
   import ser_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned BYTE_W = BYTE_W_DEF,
   parameter int unsigned IDX_W  = idx_width(WORD_W / BYTE_W)
) (
   input  logic [WORD_W-1:0] word_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [BYTE_W-1:0] lane_o
`ifdef SER_PARITY_EN
   ,
   output logic              parity_o
`endif
);

   localparam int unsigned LANES = WORD_W / BYTE_W;

   always_comb begin
      lane_o = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (idx_i == IDX_W'(i)) begin
            lane_o = word_i[i*BYTE_W +: BYTE_W];
         end
      end
   end

`ifdef SER_PARITY_EN
   assign parity_o = ^lane_o;
`endif

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops 32-bit words from the word FIFO and streams them out LSB lane first on valid/ready.
// Build macro SER_PARITY_EN adds the byte_parity output (even parity of byte_out).
module fifo_word_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned BYTE_W = BYTE_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              EN,
   input  logic [WORD_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic              fifo_rd,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
`ifdef SER_PARITY_EN
   output logic              byte_parity,
`endif
   output logic              busy
);

   localparam int unsigned LANES = WORD_W / BYTE_W;
   localparam int unsigned IDX_W = idx_width(LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   ser_state_t        state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0] lane_sel;
`ifdef SER_PARITY_EN
   logic              lane_parity;
`endif

   ser_lane_mux #(
      .WORD_W (WORD_W),
      .BYTE_W (BYTE_W),
      .IDX_W  (IDX_W)
   ) u_lane_mux (
      .word_i   (word_q),
      .idx_i    (idx_q),
      .lane_o   (lane_sel)
`ifdef SER_PARITY_EN
      ,
      .parity_o (lane_parity)
`endif
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (EN && !fifo_empty) state_d = POP;
         end
         // The FIFO ignores RD while disabled, so the pop only completes on an enabled edge.
         POP: begin
            if (EN) state_d = CAPTURE;
         end
         CAPTURE: begin
            word_d  = fifo_data;
            idx_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            if (byte_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = (EN && !fifo_empty) ? POP : IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd    = (state_q == POP);
      byte_valid = (state_q == SEND);
      byte_out   = byte_valid ? lane_sel : '0;
      byte_last  = byte_valid && (idx_q == LAST_IDX);
      busy       = (state_q != IDLE);
`ifdef SER_PARITY_EN
      byte_parity = byte_valid && lane_parity;
`endif
   end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench for fifo_word_serializer: FIFO model, byte-stream scoreboard, directed
// and randomized steps. Define SER_PARITY_EN to also check byte_parity.
module tb_fifo_word_serializer;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LANES  = WORD_W / BYTE_W;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              EN = 1'b0;
   logic [WORD_W-1:0] fifo_data = '0;
   logic              fifo_empty = 1'b1;
   logic              fifo_rd;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_ready = 1'b0;
   logic              byte_last;
   logic              busy;
`ifdef SER_PARITY_EN
   logic              byte_parity;
`endif

   always #5 Clk = ~Clk;

   fifo_word_serializer #(
      .WORD_W (WORD_W),
      .BYTE_W (BYTE_W)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .EN         (EN),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
`ifdef SER_PARITY_EN
      .byte_parity(byte_parity),
`endif
      .busy       (busy)
   );

   int checks = 0;
   int failures = 0;

   logic [WORD_W-1:0] fifo_q[$];
   logic [BYTE_W-1:0] exp_b[$];
   bit                exp_l[$];
   bit                par_log[$];
   int                xfer_cyc[$];
   int                rd_cyc[$];
   bit                pop_at_edge = 0;
   int cyc = 0, push_cyc = 0;
   int rd_cycles, valid_cycles, xfers, hold_cycles, first_valid;
   bit en_base = 1, rand_en = 0, rand_ready = 0;
   int en_block = 0, stall_left = 0;
   logic [BYTE_W-1:0] stall_byte = '0;
   bit prev_stall = 0;
   logic [BYTE_W-1:0] prev_byte = '0;
   logic prev_last = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_counts();
      rd_cycles = 0; valid_cycles = 0; xfers = 0; hold_cycles = 0; first_valid = -1;
      xfer_cyc.delete(); rd_cyc.delete(); par_log.delete();
   endtask

   task automatic push_word(input logic [WORD_W-1:0] w);
      fifo_q.push_back(w);
      push_cyc = cyc;
   endtask

   // One clock: apply the FIFO pop from the last edge, check outputs, then drive inputs.
   task automatic cycle();
      @(negedge Clk);
      if (pop_at_edge) begin
         fifo_data = fifo_q.pop_front();
         for (int i = 0; i < LANES; i++) begin
            exp_b.push_back(BYTE_W'(fifo_data >> (BYTE_W * i)));
            exp_l.push_back(i == LANES - 1);
         end
         pop_at_edge = 0;
      end
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_rd) begin
         rd_cycles++;
         rd_cyc.push_back(cyc);
         chk("rd_while_empty", 64'(fifo_empty), 0);
      end
      if (byte_valid) begin
         valid_cycles++;
         if (first_valid < 0) first_valid = cyc;
         chk("byte_expected", 64'(exp_b.size() != 0), 1);
         if (exp_b.size() != 0) begin
            chk("byte_out", 64'(byte_out), 64'(exp_b[0]));
            chk("byte_last", 64'(byte_last), 64'(exp_l[0]));
`ifdef SER_PARITY_EN
            chk("byte_parity", 64'(byte_parity), 64'(^exp_b[0]));
`endif
         end
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(byte_valid), 1);
         chk("hold_byte", 64'(byte_out), 64'(prev_byte));
         chk("hold_last", 64'(byte_last), 64'(prev_last));
      end
      byte_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (stall_left > 0 && byte_valid && byte_out == stall_byte) begin
         byte_ready = 1'b0;
         stall_left--;
         hold_cycles++;
      end
      EN = rand_en ? ($urandom_range(0, 3) != 0) : en_base;
      if (fifo_rd && en_block > 0) begin
         EN = 1'b0;
         en_block--;
      end
      if (byte_valid && byte_ready && exp_b.size() != 0) begin
         xfers++;
         xfer_cyc.push_back(cyc);
`ifdef SER_PARITY_EN
         par_log.push_back(byte_parity);
`endif
         void'(exp_b.pop_front());
         void'(exp_l.pop_front());
      end
      prev_stall  = byte_valid && !byte_ready;
      prev_byte   = byte_out;
      prev_last   = byte_last;
      pop_at_edge = fifo_rd && EN;
      cyc++;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_rd"}, 64'(fifo_rd), 0);
      chk({tag, "_valid"}, 64'(byte_valid), 0);
      chk({tag, "_last"}, 64'(byte_last), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_byte"}, 64'(byte_out), 0);
`ifdef SER_PARITY_EN
      chk({tag, "_parity"}, 64'(byte_parity), 0);
`endif
   endtask

   initial begin
      int pushed;
      int n;
      // Reset state
      #12;
      check_idle_outputs("reset");
      @(negedge Clk);
      Rst = 1'b1;
      EN = 1'b1;
      clear_counts();
      repeat (4) cycle();
      chk("empty_no_rd", 64'(rd_cycles), 0);
      chk("empty_busy", 64'(busy), 0);

      // Single word, sink always ready
      clear_counts();
      push_word(32'hA1B2C3D4);
      repeat (10) cycle();
      chk("single_latency", 64'(first_valid - push_cyc), 3);
      chk("single_rd_pulses", 64'(rd_cycles), 1);
      chk("single_xfers", 64'(xfers), 4);
      if (xfer_cyc.size() == 4) chk("single_consecutive", 64'(xfer_cyc[3] - xfer_cyc[0]), 3);
      chk("single_busy_after", 64'(busy), 0);
      chk("single_drained", 64'(exp_b.size()), 0);
`ifdef SER_PARITY_EN
      if (par_log.size() == 4)
         chk("parity_seq", 64'({par_log[0], par_log[1], par_log[2], par_log[3]}), 64'(4'b0001));
`endif

      // Backpressure on lane 1
      clear_counts();
      stall_byte = 8'hC3;
      stall_left = 3;
      push_word(32'hA1B2C3D4);
      repeat (13) cycle();
      chk("bp_hold_cycles", 64'(hold_cycles), 3);
      chk("bp_valid_cycles", 64'(valid_cycles), 7);
      chk("bp_xfers", 64'(xfers), 4);

      // Two queued words back to back
      clear_counts();
      push_word(32'h11223344);
      push_word(32'h55667788);
      repeat (18) cycle();
      chk("b2b_xfers", 64'(xfers), 8);
      chk("b2b_rd_pulses", 64'(rd_cycles), 2);
      if (xfer_cyc.size() == 8 && rd_cyc.size() == 2) begin
         chk("b2b_rd_after_last", 64'(rd_cyc[1] - xfer_cyc[3]), 1);
         chk("b2b_gap", 64'(xfer_cyc[4] - xfer_cyc[3]), 3);
         chk("b2b_word2_consec", 64'(xfer_cyc[7] - xfer_cyc[4]), 3);
      end

      // EN low for two cycles during POP
      clear_counts();
      en_block = 2;
      push_word(32'hDEADBEEF);
      repeat (12) cycle();
      chk("en_pop_rd_cycles", 64'(rd_cycles), 3);
      chk("en_pop_latency", 64'(first_valid - push_cyc), 5);
      chk("en_pop_xfers", 64'(xfers), 4);

      // EN low in IDLE blocks the start of a pop
      clear_counts();
      en_base = 0;
      push_word(32'h0BADF00D);
      repeat (5) cycle();
      chk("en_idle_no_rd", 64'(rd_cycles), 0);
      chk("en_idle_busy", 64'(busy), 0);
      en_base = 1;
      repeat (8) cycle();
      chk("en_idle_resume_xfers", 64'(xfers), 4);

      // Reset in the middle of SEND
      clear_counts();
      push_word(32'hCAFE1234);
      repeat (4) cycle();
      chk("mid_reset_sending", 64'(byte_valid), 1);
      #2 Rst = 1'b0;
      #1 check_idle_outputs("mid_reset");
      fifo_q.delete(); exp_b.delete(); exp_l.delete();
      pop_at_edge = 0;
      prev_stall = 0;
      fifo_empty = 1'b1;
      @(negedge Clk);
      Rst = 1'b1;
      clear_counts();
      repeat (4) cycle();
      chk("post_reset_no_rd", 64'(rd_cycles), 0);
      chk("post_reset_busy", 64'(busy), 0);

      // Randomized words, sink readiness and enable
      clear_counts();
      rand_ready = 1;
      rand_en = 1;
      pushed = 0;
      for (n = 0; n < 4000; n++) begin
         if (pushed == 30 && fifo_q.size() == 0 && exp_b.size() == 0 && !busy && !pop_at_edge)
            break;
         if (pushed < 30 && $urandom_range(0, 3) == 0) begin
            push_word($urandom);
            pushed++;
         end
         cycle();
      end
      chk("rand_completed", 64'(n < 4000), 1);
      chk("rand_xfers", 64'(xfers), 30 * LANES);
      chk("rand_rd_words", 64'(xfer_cyc.size() == 30 * LANES && exp_b.size() == 0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
